// File: rtl/stage1_pkg.sv
// Shared types and constants for the Stage1 max/index expander and its dictionary.
package stage1_pkg;

    localparam int IDX_W      = 4;
    localparam int DICT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        PAD,
        EMIT
    } exp_state_t;

endpackage : stage1_pkg

// File: rtl/stage1_dict_regfile.sv
// 16-entry dictionary: one synchronous write port, one combinational read port.
module stage1_dict_regfile
    import stage1_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DICT_DEPTH];

    // NOTE: the entries must read as zero after reset, so this is a flop array with a
    // reset loop rather than an inferred RAM (RAM macros cannot be cleared by reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DICT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A same-cycle write is not bypassed: the reader sees the old entry.
    assign rdata_o = mem_q[raddr_i];

endmodule : stage1_dict_regfile

// File: rtl/max_index_expander.sv
// Expands {len, idx, align} tokens into runs of dictionary symbols on a valid/ready
// stream, optionally padding the stream to an ALIGN-beat boundary first.
module max_index_expander
    import stage1_pkg::*;
#(
    parameter int                WIDTH     = 2,
    parameter int                DATA_W    = 8,
    parameter int                ALIGN     = 4,
    parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_dict_we,
    input  logic [IDX_W-1:0]  i_dict_addr,
    input  logic [DATA_W-1:0] i_dict_data,
    input  logic              i_tok_valid,
    output logic              o_tok_ready,
    input  logic [WIDTH-1:0]  i_len,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_align,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_pad,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(ALIGN);

    exp_state_t        state_q, state_d;
    logic [WIDTH-1:0]  run_q, run_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pad_q, pad_d;

    logic              out_free;
    logic              beat_acc;
    logic              tok_acc;
    logic [CNT_W-1:0]  next_pos;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] dict_rdata;

    stage1_dict_regfile #(
        .DATA_W (DATA_W)
    ) u_dict (
        .clk     (clk),
        .rst     (rst),
        .we_i    (i_dict_we),
        .waddr_i (i_dict_addr),
        .wdata_i (i_dict_data),
        .raddr_i (rd_idx),
        .rdata_o (dict_rdata)
    );

    assign out_free = !valid_q || i_ready;
    assign beat_acc = valid_q && i_ready;
    assign tok_acc  = i_tok_valid && o_tok_ready;
    assign rd_idx   = (state_q == IDLE) ? i_idx : idx_q;

    // Alignment position of the next beat to be loaded: a pending beat always drains
    // before it, so it is counted as already sent.
    assign next_pos = beat_cnt_q + CNT_W'(valid_q);

    // NOTE: every always_comb output gets its default first, so no path can leave a
    // signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        data_d     = data_q;
        pad_d      = pad_q;
        beat_cnt_d = beat_cnt_q + CNT_W'(beat_acc);

        if (out_free) begin
            valid_d = 1'b0;
            pad_d   = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tok_acc) begin
                        idx_d = i_idx;
                        if (i_len != '0) begin
                            valid_d = 1'b1;
                            if (i_align && next_pos != '0) begin
                                state_d = PAD;
                                run_d   = i_len;
                                data_d  = PAD_VALUE;
                                pad_d   = 1'b1;
                            end else begin
                                state_d = EMIT;
                                run_d   = i_len - WIDTH'(1);
                                data_d  = dict_rdata;
                            end
                        end
                    end
                end
                PAD: begin
                    valid_d = 1'b1;
                    if (next_pos != '0) begin
                        data_d = PAD_VALUE;
                        pad_d  = 1'b1;
                    end else begin
                        state_d = EMIT;
                        run_d   = run_q - WIDTH'(1);
                        data_d  = dict_rdata;
                    end
                end
                EMIT: begin
                    if (run_q != '0) begin
                        valid_d = 1'b1;
                        run_d   = run_q - WIDTH'(1);
                        data_d  = dict_rdata;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            run_q      <= '0;
            idx_q      <= '0;
            beat_cnt_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            pad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            idx_q      <= idx_d;
            beat_cnt_q <= beat_cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            pad_q      <= pad_d;
        end
    end

    assign o_tok_ready = !rst && (state_q == IDLE) && out_free;
    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_pad       = pad_q;
    assign o_busy      = (state_q != IDLE);

endmodule : max_index_expander

// File: tb/tb_max_index_expander.sv
// Directed bench for max_index_expander: token vector table plus stall, dictionary
// write-collision and mid-run reset sequences.
module tb_max_index_expander;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_dict_we;
    logic [3:0] i_dict_addr;
    logic [7:0] i_dict_data;
    logic       i_tok_valid;
    logic       o_tok_ready;
    logic [1:0] i_len;
    logic [3:0] i_idx;
    logic       i_align;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_pad;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] len;
        logic [3:0] idx;
        logic       align;
        int         pads;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [9];

    max_index_expander dut (
        .clk         (clk),
        .rst         (rst),
        .i_dict_we   (i_dict_we),
        .i_dict_addr (i_dict_addr),
        .i_dict_data (i_dict_data),
        .i_tok_valid (i_tok_valid),
        .o_tok_ready (o_tok_ready),
        .i_len       (i_len),
        .i_idx       (i_idx),
        .i_align     (i_align),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_pad       (o_pad),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_dict(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        i_dict_we   = 1'b1;
        i_dict_addr = addr;
        i_dict_data = data;
        @(negedge clk);
        i_dict_we   = 1'b0;
    endtask

    // Presents a token until it is taken; returns just after the accepting edge.
    task automatic send_token(input logic [1:0] len, input logic [3:0] idx,
                              input logic align, output logic ok);
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            i_tok_valid = 1'b1;
            i_len       = len;
            i_idx       = idx;
            i_align     = align;
            #1;
            if (o_tok_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL tok_ready timeout: got 0 expected 1");
            i_tok_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic       ok;
        logic [9:0] exp;
        int         total;
        total = v.pads + int'(v.len);
        i_ready = 1'b1;
        send_token(v.len, v.idx, v.align, ok);
        if (ok) begin
            for (int k = 0; k < total; k++) begin
                @(negedge clk);
                i_tok_valid = 1'b0;
                #1;
                exp = (k < v.pads) ? {1'b1, 1'b1, 8'h00} : {1'b1, 1'b0, v.data};
                check($sformatf("%s beat%0d {valid,pad,data}", tag, k), {o_valid, o_pad, o_data}, exp);
            end
            @(negedge clk);
            i_tok_valid = 1'b0;
            #1;
            check({tag, " end o_valid"}, o_valid, 0);
            check({tag, " end o_busy"}, o_busy, 0);
            check({tag, " end o_tok_ready"}, o_tok_ready, 1);
        end
    endtask

    initial begin
        logic       ok;
        logic       prev_stall;
        logic [9:0] saved;
        int         accepted;
        int         cyc;
        bit         done;

        // Expected pads follow beat_cnt from reset: 0,3,1,2,2,1,3,0,2 before each token.
        vecs[0] = '{len: 2'd3, idx: 4'd3,  align: 1'b0, pads: 0, data: 8'hA5};
        vecs[1] = '{len: 2'd1, idx: 4'd9,  align: 1'b1, pads: 1, data: 8'hC3};
        vecs[2] = '{len: 2'd2, idx: 4'd5,  align: 1'b1, pads: 3, data: 8'h3C};
        vecs[3] = '{len: 2'd0, idx: 4'd7,  align: 1'b1, pads: 0, data: 8'h00};
        vecs[4] = '{len: 2'd3, idx: 4'd15, align: 1'b0, pads: 0, data: 8'hF0};
        vecs[5] = '{len: 2'd3, idx: 4'd1,  align: 1'b1, pads: 3, data: 8'h5A};
        vecs[6] = '{len: 2'd1, idx: 4'd5,  align: 1'b0, pads: 0, data: 8'h3C};
        vecs[7] = '{len: 2'd2, idx: 4'd9,  align: 1'b1, pads: 0, data: 8'hC3};
        vecs[8] = '{len: 2'd3, idx: 4'd3,  align: 1'b1, pads: 2, data: 8'hA5};

        rst         = 1'b1;
        i_dict_we   = 1'b0;
        i_dict_addr = '0;
        i_dict_data = '0;
        i_tok_valid = 1'b1;
        i_len       = 2'd3;
        i_idx       = 4'd3;
        i_align     = 1'b0;
        i_ready     = 1'b1;

        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst o_valid", o_valid, 0);
        check("rst o_data", o_data, 0);
        check("rst o_pad", o_pad, 0);
        check("rst o_busy", o_busy, 0);
        check("rst o_tok_ready", o_tok_ready, 0);
        @(negedge clk);
        rst         = 1'b0;
        i_tok_valid = 1'b0;

        write_dict(4'd3,  8'hA5);
        write_dict(4'd5,  8'h3C);
        write_dict(4'd1,  8'h5A);
        write_dict(4'd9,  8'hC3);
        write_dict(4'd15, 8'hF0);
        write_dict(4'd2,  8'h22);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Stall: beat_cnt is 3 here, align=0 so no padding either way.
        send_token(2'd3, 4'd1, 1'b0, ok);
        if (ok) begin
            for (int s = 0; s < 4; s++) begin
                @(negedge clk);
                i_ready     = 1'b0;
                i_tok_valid = 1'b1;
                i_len       = 2'd1;
                i_idx       = 4'd3;
                i_align     = 1'b0;
                #1;
                check($sformatf("stall hold%0d {valid,pad,data}", s), {o_valid, o_pad, o_data}, {1'b1, 1'b0, 8'h5A});
                check($sformatf("stall hold%0d o_busy", s), o_busy, 1);
                check($sformatf("stall hold%0d busy tok_ready", s), o_tok_ready, 0);
            end
            prev_stall = 1'b1;
            saved      = {1'b1, 1'b0, 8'h5A};
            accepted   = 0;
            done       = 1'b0;
            cyc        = 0;
            while (!done && cyc < 200) begin
                @(negedge clk);
                i_tok_valid = 1'b0;
                i_ready     = 1'($urandom_range(0, 1));
                #1;
                if (prev_stall) check("stall stable", {o_valid, o_pad, o_data}, saved);
                if (o_valid && i_ready) begin
                    accepted++;
                    check("stall beat data", {o_pad, o_data}, {1'b0, 8'h5A});
                end
                prev_stall = o_valid && !i_ready;
                saved      = {o_valid, o_pad, o_data};
                done       = !o_busy && !o_valid;
                cyc++;
            end
            check("stall run finished", done, 1);
            check("stall beats accepted", accepted, 3);
            i_ready = 1'b1;
            @(negedge clk);
            #1;
            check("stall no extra beat", o_valid, 0);
        end

        // Dictionary write in the cycle the 2nd beat loads: old, old, new.
        i_ready = 1'b1;
        send_token(2'd3, 4'd2, 1'b0, ok);
        if (ok) begin
            @(negedge clk);
            i_tok_valid = 1'b0;
            #1;
            check("wr beat0", {o_valid, o_data}, {1'b1, 8'h22});
            i_dict_we   = 1'b1;
            i_dict_addr = 4'd2;
            i_dict_data = 8'h11;
            @(negedge clk);
            i_dict_we = 1'b0;
            #1;
            check("wr beat1 old value", {o_valid, o_data}, {1'b1, 8'h22});
            @(negedge clk);
            #1;
            check("wr beat2 new value", {o_valid, o_data}, {1'b1, 8'h11});
            @(negedge clk);
            #1;
            check("wr end o_valid", o_valid, 0);
        end

        // Reset during the 2nd beat of a run.
        send_token(2'd3, 4'd3, 1'b0, ok);
        if (ok) begin
            @(negedge clk);
            i_tok_valid = 1'b0;
            #1;
            check("rstmid beat0", {o_valid, o_data}, {1'b1, 8'hA5});
            @(negedge clk);
            #1;
            check("rstmid beat1", {o_valid, o_data}, {1'b1, 8'hA5});
            rst = 1'b1;
            #1;
            check("rstmid o_valid", o_valid, 0);
            check("rstmid o_busy", o_busy, 0);
            check("rstmid o_data", o_data, 0);
            check("rstmid o_tok_ready", o_tok_ready, 0);
            @(negedge clk);
            rst = 1'b0;
        end
        // beat_cnt restarts at 0 (no padding) and dict[3] reads back cleared.
        run_vec('{len: 2'd1, idx: 4'd3, align: 1'b1, pads: 0, data: 8'h00}, "post_rst0");
        run_vec('{len: 2'd1, idx: 4'd3, align: 1'b1, pads: 3, data: 8'h00}, "post_rst1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_max_index_expander
